pixel_frame_packer: RTL and testbench
=====================================

Name: pixel_frame_packer

Overview:
- Downstream consumer of the processing top's 8-bit `pixel_out`/`valid_out`/`ready_out` stream, in the `clk` (100 MHz) domain.
- Frames a fixed IMG_W x IMG_H image and packs 4 pixels into each 32-bit word for a memory/bus writer.
- Tags each word with start-of-frame, end-of-line and end-of-frame flags.
- Provides single-shot or continuous capture with full backpressure in both directions.

Parameters:
- IMG_W, 32, pixels per line; must be a multiple of 4 and at least 4.
- IMG_H, 32, lines per frame; at least 1.
- CONTINUOUS, 0, 1 = re-arm automatically after each frame; 0 = return to IDLE after one frame.

Ports:
- clk  input  1  processing clock.
- resetn  input  1  reset; synchronous, active-low.
- start  input  1  capture request; sampled only in IDLE.
- pix_in  input  8  pixel from the processing stage.
- pix_valid  input  1  pix_in is valid.
- pix_ready  output  1  packer accepts pix_in this cycle.
- word_out  output  32  packed word; first pixel of the group in [7:0], fourth pixel in [31:24].
- word_valid  output  1  word_out and its flags are valid.
- word_ready  input  1  sink accepts the word.
- word_sof  output  1  word holds pixel (row 0, col 0).
- word_eol  output  1  word holds col IMG_W-1.
- word_eof  output  1  word holds the last pixel of the frame.
- busy  output  1  state is not IDLE.
- frame_done  output  1  one-cycle pulse on the cycle after the eof word handshakes.
- frame_count  output  16  number of completed frames; wraps at 16 bits.

Behaviour:
- Reset: while resetn is low at a clk edge:
  - state=IDLE; lane, col and row counters = 0.
  - word_valid=0, word_out=0, all flags=0.
  - frame_done=0, frame_count=0.
  - Any partial word is discarded.
- Handshakes: a pixel transfers when pix_valid && pix_ready; a word transfers when word_valid && word_ready.
  - word_out and its flags stay stable while word_valid && !word_ready.
- Output slot: single register; out_free = !word_valid || word_ready.
- FSM states:
  - IDLE:
    - pix_ready=1; pixels are accepted and discarded (no upstream stall).
    - start=1 → CAPTURE next cycle; counters are already 0.
    - A pixel handshake in the same cycle as start is discarded.
  - CAPTURE:
    - pix_ready = (lane != 3) || out_free. This is a combinational path from word_ready, and it is intended.
    - Lanes 0–2: the pixel goes into byte [8*lane +: 8] of the staging register; lane increments.
    - Lane 3: on the next edge, word_out = {pix_in, staging[23:0]} and word_valid=1. Latency is 1 cycle after the 4th pixel handshake.
    - Lane wraps to 0. col advances by 4 per word; at IMG_W it wraps to 0 and row increments.
    - Flags are computed from col/row at word formation.
    - When the eof word is formed → DRAIN.
  - DRAIN:
    - pix_ready=0.
    - On the eof word handshake: frame_done=1 on the next cycle and frame_count+1.
    - Next state is CAPTURE (counters 0) if CONTINUOUS=1, else IDLE.
- Flags with IMG_W=4: sof and eol can coincide on one word. With IMG_W=4, IMG_H=1: sof, eol and eof are all set on the single word.
- Same-cycle events: a word handshake and a new lane-3 pixel in the same cycle load the new word with no bubble; word_valid stays 1.
- start while in CAPTURE or DRAIN is ignored.
- pix_valid low mid-word holds lane and staging indefinitely; there is no timeout.
- Reset mid-frame: the partial frame is lost, frame_count is cleared, and the next capture needs a new start.
- frame_count wraps 0xFFFF → 0x0000 with no flag.

Test Plan:
- Reset check: hold resetn low 5 cycles with pix_valid=1 → word_valid=0, busy=0, frame_count=0, pix_ready=1.
- Basic pack (IMG_W=8, IMG_H=2, CONTINUOUS=0): start, then stream 0x00..0x0F with word_ready=1 →
  - words 0x03020100 (sof, eol=0), 0x07060504 (eol), 0x0B0A0908, 0x0F0E0D0C (eol, eof).
  - frame_done pulses once, frame_count=1, busy=0.
- Backpressure: same stream with word_ready=0 for 6 cycles after the first word →
  - word_out holds 0x03020100.
  - pix_ready drops at lane 3, and no pixel is lost or duplicated.
- Idle discard: stream 0xAA x3 before start, then start and 0x00..0x0F → first word = 0x03020100; 0xAA never appears.
- Continuous (CONTINUOUS=1, IMG_W=4, IMG_H=1): four frames of 0x10,0x11,0x12,0x13 →
  - four words 0x13121110, each with sof, eol and eof set.
  - frame_count=4, busy stays 1.
- Mid-frame reset: reset after 6 pixels, then start and 16 pixels → clean frame identical to the Basic pack case, frame_count=1.

Source files
------------

// File: rtl/pixel_frame_packer_if.sv
// ----------------------------------------------------------------------------
// pixel_frame_packer_if
//
// Bundles the two streaming handshakes around the pixel frame packer:
//   * pixel stream  : pix_in[7:0], pix_valid, pix_ready
//   * word stream   : word_out[31:0], word_valid, word_ready,
//                     word_sof, word_eol, word_eof
//
// Modports:
//   master - the surrounding system: sources pixels and sinks packed words.
//   slave  - the packer itself: sinks pixels and sources packed words.
// ----------------------------------------------------------------------------
interface pixel_frame_packer_if;

  // Pixel stream from the processing stage
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_ready;

  // Packed word stream towards the memory/bus writer
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        word_sof;
  logic        word_eol;
  logic        word_eof;

  modport master (
    output pix_in,
    output pix_valid,
    input  pix_ready,
    input  word_out,
    input  word_valid,
    output word_ready,
    input  word_sof,
    input  word_eol,
    input  word_eof
  );

  modport slave (
    input  pix_in,
    input  pix_valid,
    output pix_ready,
    output word_out,
    output word_valid,
    input  word_ready,
    output word_sof,
    output word_eol,
    output word_eof
  );

endinterface

// File: rtl/pixel_frame_packer.sv
// ----------------------------------------------------------------------------
// pixel_frame_packer
//
// Frames a fixed IMG_W x IMG_H image arriving as an 8-bit pixel stream and
// packs every four consecutive pixels into one 32-bit word (first pixel in
// [7:0], fourth in [31:24]). Each word carries start-of-frame, end-of-line
// and end-of-frame tags. Capture is single-shot (return to IDLE after one
// frame) or continuous (re-arm automatically) depending on CONTINUOUS.
//
// Parameters:
//   IMG_W       pixels per line, multiple of 4, >= 4
//   IMG_H       lines per frame, >= 1
//   CONTINUOUS  1 = re-arm after each frame, 0 = single frame per start
//
// Ports:
//   clk          processing clock
//   resetn       synchronous active-low reset
//   start        capture request, only honoured in IDLE
//   bus          slave side of pixel_frame_packer_if (pixel in, word out)
//   busy         high whenever the FSM is not in IDLE
//   frame_done   one-cycle pulse the cycle after the eof word handshakes
//   frame_count  completed frames, wraps at 16 bits
// ----------------------------------------------------------------------------
module pixel_frame_packer #(
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  pixel_frame_packer_if.slave  bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [15:0]          frame_count
);

  // --------------------------------------------------------------------------
  // Geometry
  // --------------------------------------------------------------------------
  // col holds the column of the first pixel of the word being assembled, so
  // it always steps by 4 and its two LSBs stay zero.
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 4);
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(4);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [1:0]         lane_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [2:0][7:0]    staging_q;

  logic [31:0]        word_q;
  logic               word_valid_q;
  logic               word_sof_q;
  logic               word_eol_q;
  logic               word_eof_q;

  logic               pix_ready_c;
  logic               out_free;
  logic               pix_fire;
  logic               word_fire;
  logic               capture_fire;
  logic               form_word;
  logic               at_sof;
  logic               at_eol;
  logic               at_eof;

  // --------------------------------------------------------------------------
  // Handshake qualifiers
  // --------------------------------------------------------------------------
  assign out_free     = !word_valid_q || bus.word_ready;
  assign pix_fire     = bus.pix_valid && pix_ready_c;
  assign word_fire    = word_valid_q && bus.word_ready;
  assign capture_fire = (state_q == S_CAPTURE) && pix_fire;
  assign form_word    = capture_fire && (lane_q == 2'd3);

  // Position tags of the word currently being completed
  assign at_sof = (col_q == '0) && (row_q == '0);
  assign at_eol = (col_q == COL_LAST);
  assign at_eof = at_eol && (row_q == ROW_LAST);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all
  // registers update from the same pre-edge values, independent of the
  // order in which the simulator evaluates the processes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  // NOTE: the default assignment at the top of each combinational process
  // guarantees every path drives every output, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (form_word && at_eof) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The only word that can be pending here is the eof word.
        if (word_fire) begin
          state_d = CONTINUOUS ? S_CAPTURE : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  // In CAPTURE the fourth pixel can only be taken when the output slot is
  // free this cycle; this makes pix_ready combinationally depend on
  // word_ready, which keeps the stream bubble-free under full throughput.
  always_comb begin
    pix_ready_c = 1'b0;
    busy        = 1'b1;
    case (state_q)
      S_IDLE: begin
        pix_ready_c = 1'b1;   // swallow pixels so upstream never stalls
        busy        = 1'b0;
      end
      S_CAPTURE: begin
        pix_ready_c = (lane_q != 2'd3) || out_free;
      end
      S_DRAIN: begin
        pix_ready_c = 1'b0;
      end
      default: begin
        pix_ready_c = 1'b0;
        busy        = 1'b0;
      end
    endcase
  end

  assign bus.pix_ready = pix_ready_c;

  // --------------------------------------------------------------------------
  // Lane / column / row counters
  // --------------------------------------------------------------------------
  // Counters wrap back to zero on the eof word, so they are already cleared
  // when the FSM returns to IDLE or re-arms in continuous mode.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lane_q <= 2'd0;
      col_q  <= '0;
      row_q  <= '0;
    end else if (capture_fire) begin
      lane_q <= lane_q + 2'd1;
      if (lane_q == 2'd3) begin
        if (at_eol) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_STEP;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Staging register for pixels 0..2 of the current group
  // --------------------------------------------------------------------------
  // NOTE: the staging bytes are deliberately left out of reset; a partial
  // group is discarded by clearing lane_q, and every byte is rewritten
  // before it can ever reach word_out.
  always_ff @(posedge clk) begin
    if (capture_fire) begin
      case (lane_q)
        2'd0:    staging_q[0] <= bus.pix_in;
        2'd1:    staging_q[1] <= bus.pix_in;
        2'd2:    staging_q[2] <= bus.pix_in;
        default: staging_q    <= staging_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output slot
  // --------------------------------------------------------------------------
  // A new word may load in the same cycle the previous one is accepted,
  // in which case word_valid simply stays high.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
      word_sof_q   <= 1'b0;
      word_eol_q   <= 1'b0;
      word_eof_q   <= 1'b0;
    end else if (form_word) begin
      word_q       <= {bus.pix_in, staging_q[2], staging_q[1], staging_q[0]};
      word_valid_q <= 1'b1;
      word_sof_q   <= at_sof;
      word_eol_q   <= at_eol;
      word_eof_q   <= at_eof;
    end else if (word_fire) begin
      word_valid_q <= 1'b0;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_sof   = word_sof_q;
  assign bus.word_eol   = word_eol_q;
  assign bus.word_eof   = word_eof_q;

  // --------------------------------------------------------------------------
  // Frame completion
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_done  <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      if ((state_q == S_DRAIN) && word_fire) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_packer.sv
// ----------------------------------------------------------------------------
// tb_pixel_frame_packer
//
// Two packers run side by side: dut_a (8x2, single-shot) and dut_b
// (4x1, continuous). Drivers push the expected words of a simple frame
// model into per-DUT queues; a negedge monitor pops and compares whenever a
// word handshakes, and also tracks frame_done / frame_count and output
// stability under backpressure.
// ----------------------------------------------------------------------------
module tb_pixel_frame_packer;

  typedef struct packed {
    logic [31:0] data;
    logic        sof;
    logic        eol;
    logic        eof;
  } word_t;

  localparam int NDUT    = 2;
  localparam int A_W     = 8;
  localparam int A_H     = 2;
  localparam int B_W     = 4;
  localparam int B_H     = 1;
  localparam int BUDGET  = 1000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  // Stimulus, per DUT
  logic [7:0] px_d [NDUT];
  logic       px_v [NDUT];
  logic       wr   [NDUT];
  logic       st   [NDUT];
  bit         rand_ready [NDUT];

  // Observations, per DUT
  logic        pr  [NDUT];
  word_t       ow  [NDUT];
  logic        ov  [NDUT];
  logic        ob  [NDUT];
  logic        ofd [NDUT];
  logic [15:0] ofc [NDUT];

  logic        busy_a, busy_b, fd_a, fd_b;
  logic [15:0] fc_a, fc_b;

  pixel_frame_packer_if bus_a ();
  pixel_frame_packer_if bus_b ();

  pixel_frame_packer #(.IMG_W(A_W), .IMG_H(A_H), .CONTINUOUS(1'b0)) dut_a (
    .clk(clk), .resetn(resetn), .start(st[0]), .bus(bus_a),
    .busy(busy_a), .frame_done(fd_a), .frame_count(fc_a)
  );

  pixel_frame_packer #(.IMG_W(B_W), .IMG_H(B_H), .CONTINUOUS(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .start(st[1]), .bus(bus_b),
    .busy(busy_b), .frame_done(fd_b), .frame_count(fc_b)
  );

  assign bus_a.pix_in     = px_d[0];
  assign bus_a.pix_valid  = px_v[0];
  assign bus_a.word_ready = wr[0];
  assign bus_b.pix_in     = px_d[1];
  assign bus_b.pix_valid  = px_v[1];
  assign bus_b.word_ready = wr[1];

  assign pr[0]  = bus_a.pix_ready;
  assign pr[1]  = bus_b.pix_ready;
  assign ow[0]  = {bus_a.word_out, bus_a.word_sof, bus_a.word_eol, bus_a.word_eof};
  assign ow[1]  = {bus_b.word_out, bus_b.word_sof, bus_b.word_eol, bus_b.word_eof};
  assign ov[0]  = bus_a.word_valid;
  assign ov[1]  = bus_b.word_valid;
  assign ob[0]  = busy_a;
  assign ob[1]  = busy_b;
  assign ofd[0] = fd_a;
  assign ofd[1] = fd_b;
  assign ofc[0] = fc_a;
  assign ofc[1] = fc_b;

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: frame = IMG_W*IMG_H pixels in order, 4 per word
  // --------------------------------------------------------------------------
  word_t      exp_q [NDUT][$];
  logic [7:0] grp   [NDUT][$];
  int         wcnt  [NDUT];
  bit         capturing [NDUT];

  function automatic int img_w(input int id);
    return (id == 0) ? A_W : B_W;
  endfunction

  function automatic int img_h(input int id);
    return (id == 0) ? A_H : B_H;
  endfunction

  task automatic model_px(input int id, input logic [7:0] d);
    word_t w;
    int    wpl;
    int    wpf;
    if (!capturing[id]) return;          // IDLE pixels vanish
    grp[id].push_back(d);
    if (grp[id].size() == 4) begin
      wpl    = img_w(id) / 4;
      wpf    = wpl * img_h(id);
      w.data = {grp[id][3], grp[id][2], grp[id][1], grp[id][0]};
      w.sof  = (wcnt[id] == 0);
      w.eol  = ((wcnt[id] % wpl) == wpl - 1);
      w.eof  = (wcnt[id] == wpf - 1);
      exp_q[id].push_back(w);
      grp[id].delete();
      wcnt[id] = (wcnt[id] + 1) % wpf;
      if (w.eof && id == 0) capturing[id] = 1'b0;   // single-shot DUT
    end
  endtask

  task automatic model_clear();
    for (int id = 0; id < NDUT; id++) begin
      capturing[id] = 1'b0;
      grp[id].delete();
      exp_q[id].delete();
      wcnt[id] = 0;
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor (samples on negedge; inputs only change just after posedge)
  // --------------------------------------------------------------------------
  bit          mon_en = 1'b0;
  bit          prev_eof_hs [NDUT];
  bit          prev_stall  [NDUT];
  word_t       prev_w      [NDUT];
  logic [15:0] exp_fc      [NDUT];

  task automatic monitor_one(input int id);
    word_t e;
    if (prev_stall[id]) begin
      check($sformatf("hold_valid%0d", id), ov[id], 1'b1);
      check($sformatf("hold_word%0d", id), ow[id], prev_w[id]);
    end
    check($sformatf("frame_done%0d", id), ofd[id], prev_eof_hs[id]);
    check($sformatf("frame_count%0d", id), ofc[id], exp_fc[id]);
    prev_eof_hs[id] = 1'b0;
    prev_stall[id]  = 1'b0;
    if (!resetn) begin
      exp_fc[id] = 16'd0;
    end else if (ov[id] === 1'b1 && wr[id] === 1'b1) begin
      if (exp_q[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word%0d: got 0x%0h expected none", id, ow[id]);
      end else begin
        e = exp_q[id].pop_front();
        check($sformatf("word%0d", id), ow[id], e);
      end
      if (ow[id].eof) begin
        prev_eof_hs[id] = 1'b1;
        exp_fc[id]      = exp_fc[id] + 16'd1;
      end
    end else if (ov[id] === 1'b1) begin
      prev_stall[id] = 1'b1;
      prev_w[id]     = ow[id];
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      monitor_one(0);
      monitor_one(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sink: random word_ready when enabled
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int id = 0; id < NDUT; id++) begin
        if (rand_ready[id]) wr[id] = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic send_px(input int id, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    px_d[id] = d;
    px_v[id] = 1'b1;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (pr[id] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL pix_timeout%0d: pix_ready stuck low for %0d cycles", id, BUDGET);
      px_v[id] = 1'b0;
      return;
    end
    model_px(id, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_px(input int id, input int n);
    px_v[id] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int id);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (ob[id] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout%0d: busy stuck high for %0d cycles", id, BUDGET);
    end
    @(posedge clk);
    #1;
  endtask

  // Start pulse; optionally offer a junk pixel in the same cycle.
  task automatic do_start(input int id, input bit junk);
    st[id]   = 1'b1;
    px_v[id] = junk;
    px_d[id] = 8'hAA;
    @(posedge clk);
    #1;
    st[id]        = 1'b0;
    px_v[id]      = 1'b0;
    capturing[id] = 1'b1;
    grp[id].delete();
    wcnt[id] = 0;
  endtask

  task automatic stream_ramp(input int id, input int n);
    for (int i = 0; i < n; i++) send_px(id, 8'(i));
    px_v[id] = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    for (int id = 0; id < NDUT; id++) begin
      px_d[id] = 8'h55;
      px_v[id] = 1'b1;
      wr[id]   = 1'b1;
      st[id]   = 1'b0;
      rand_ready[id]  = 1'b0;
      prev_eof_hs[id] = 1'b0;
      prev_stall[id]  = 1'b0;
      exp_fc[id]      = 16'd0;
    end
    model_clear();

    // Reset with pixels being offered
    resetn = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int id = 0; id < NDUT; id++) begin
      check($sformatf("rst_word_valid%0d", id), ov[id], 1'b0);
      check($sformatf("rst_busy%0d", id), ob[id], 1'b0);
      check($sformatf("rst_frame_count%0d", id), ofc[id], 16'd0);
      check($sformatf("rst_pix_ready%0d", id), pr[id], 1'b1);
      check($sformatf("rst_word_out%0d", id), ow[id], '0);
    end
    @(posedge clk);
    #1;
    px_v[0] = 1'b0;
    px_v[1] = 1'b0;
    resetn  = 1'b1;
    mon_en  = 1'b1;
    idle_px(0, 2);

    // Basic pack
    do_start(0, 1'b0);
    stream_ramp(0, 16);
    wait_idle(0);
    check("basic_frame_count", ofc[0], 16'd1);
    check("basic_busy", ob[0], 1'b0);

    // Backpressure: hold the first word for several cycles
    do_start(0, 1'b0);
    wr[0] = 1'b0;
    fork
      stream_ramp(0, 16);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
          @(negedge clk);
          if (ov[0] === 1'b1) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          checks++;
          errors++;
          $display("FAIL bp_word_timeout: no word within %0d cycles", BUDGET);
        end
        repeat (6) @(negedge clk);
        check("bp_pix_ready_stall", pr[0], 1'b0);
        check("bp_word_hold", ow[0].data, 32'h0302_0100);
        @(posedge clk);
        #1;
        wr[0] = 1'b1;
      end
    join
    wait_idle(0);
    check("bp_frame_count", ofc[0], 16'd2);

    // Idle discard, including a pixel offered together with start
    for (int i = 0; i < 3; i++) send_px(0, 8'hAA);
    idle_px(0, 1);
    do_start(0, 1'b1);
    stream_ramp(0, 16);
    wait_idle(0);
    check("idle_frame_count", ofc[0], 16'd3);

    // Mid-frame reset
    do_start(0, 1'b0);
    stream_ramp(0, 6);
    idle_px(0, 3);
    check("pre_rst_sb_empty", exp_q[0].size(), 0);
    resetn = 1'b0;
    model_clear();
    idle_px(0, 2);
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", ob[0], 1'b0);
    check("mid_rst_word_valid", ov[0], 1'b0);
    check("mid_rst_frame_count", ofc[0], 16'd0);
    @(posedge clk);
    #1;
    do_start(0, 1'b0);
    stream_ramp(0, 16);
    wait_idle(0);
    check("mid_rst_clean_frame_count", ofc[0], 16'd1);

    // Continuous capture on the 4x1 packer
    do_start(1, 1'b0);
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < 4; p++) send_px(1, 8'h10 + 8'(p));
    end
    idle_px(1, 8);
    @(negedge clk);
    check("cont_frame_count", ofc[1], 16'd4);
    check("cont_busy", ob[1], 1'b1);
    @(posedge clk);
    #1;

    // Randomized traffic on both packers with random sink stalls
    rand_ready[0] = 1'b1;
    rand_ready[1] = 1'b1;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          do_start(0, 1'($urandom_range(0, 1)));
          for (int i = 0; i < A_W * A_H; i++) begin
            if ($urandom_range(0, 3) == 0) idle_px(0, $urandom_range(1, 3));
            send_px(0, 8'($urandom));
          end
          px_v[0] = 1'b0;
          wait_idle(0);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) idle_px(1, $urandom_range(1, 3));
          send_px(1, 8'($urandom));
        end
        px_v[1] = 1'b0;
      end
    join
    rand_ready[0] = 1'b0;
    rand_ready[1] = 1'b0;
    @(posedge clk);
    #1;
    wr[0] = 1'b1;
    wr[1] = 1'b1;
    idle_px(0, 10);
    check("final_sb_empty0", exp_q[0].size(), 0);
    check("final_sb_empty1", exp_q[1].size(), 0);
    check("final_frame_count0", ofc[0], 16'd4);
    check("final_frame_count1", ofc[1], 16'd14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
